// File: rtl/aes_inv_key_sched_if.sv
// Handshake and data bundle between the AES-128 decryption key scheduler and its consumer.
// master: start/key_in/rk_ready side; slave: the scheduler itself.
interface aes_inv_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_idx, rk_last
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_idx, rk_last
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 decryption key scheduler: expands to round key 10, then walks back to round key 0.
// Latency: 10 cycles from accepted start to first rk_valid; one key per handshake afterwards.
// Backpressure: rk_out/rk_idx hold while rk_valid && !rk_ready; rk_valid never depends on rk_ready combinationally.
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_key_sched_if.slave   ks
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    // Entry x sits at bits [8*(255-x)+7 -: 8], i.e. the index {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           vld_q, vld_d;
    logic           busy_q, busy_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    inv_w1, inv_w2, inv_w3;
    logic [31:0]    sub_src, t;
    logic [3:0]     rc_idx;
    logic [31:0]    f0, f1, f2, f3;
    logic [127:0]   fwd_key, inv_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;

    // One SubWord instance serves both directions: forward uses w3, inverse uses the recovered w3.
    assign sub_src = (state_q == FWD) ? w3 : inv_w3;
    assign rc_idx  = (state_q == FWD) ? cnt_q : idx_q - 4'd1;
    assign t       = sub_word({sub_src[23:0], sub_src[31:24]}) ^ {rcon(rc_idx), 24'h0};

    assign f0      = w0 ^ t;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {w0 ^ t, inv_w1, inv_w2, inv_w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    key_d   = ks.key_in;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = FWD;
                end
            end
            FWD: begin
                key_d = fwd_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(NR - 1)) begin
                    idx_d   = 4'(NR);
                    vld_d   = 1'b1;
                    state_d = REV;
                end
            end
            REV: begin
                if (ks.rk_ready) begin
                    if (idx_q == 4'd0) begin
                        vld_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        key_d = inv_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ks.busy     = busy_q;
    assign ks.rk_valid = vld_q;
    assign ks.rk_out   = key_q;
    assign ks.rk_idx   = idx_q;
    assign ks.rk_last  = vld_q & (idx_q == 4'd0);

endmodule
